// File: rtl/echo_pkg.sv
// -----------------------------------------------------------------------------
// echo_pkg
//   Widths and types shared by the random signal generator, the sample capture
//   block and the echo canceller. Keeping them here means all three blocks
//   agree on sample and counter widths.
//   Contents:
//     SAMPLE_W  - test-signal sample width
//     CNT_W     - width of the shared sampling_cycle_counter
//     sample_t  - one signal sample
//     cnt_t     - sampling-cycle counter value
//     sat_inc16 - 16-bit increment that sticks at 16'hFFFF
// -----------------------------------------------------------------------------
package echo_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 13;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage : echo_pkg

// File: rtl/signal_sample_capture_if.sv
// -----------------------------------------------------------------------------
// signal_sample_capture_if
//   Valid/ready drain interface of the sample capture FIFO.
//   Signals:
//     out_valid  - head sample available (FIFO not empty)
//     out_ready  - consumer accepts the head sample this clock
//     out_sample - head sample, meaningful only while out_valid=1
//   Modports:
//     master - the capture block (drives valid and sample)
//     slave  - the consumer (drives ready)
// -----------------------------------------------------------------------------
interface signal_sample_capture_if #(
  parameter int SAMPLE_W = echo_pkg::SAMPLE_W
);

  logic                out_valid;
  logic                out_ready;
  logic [SAMPLE_W-1:0] out_sample;

  modport master (
    output out_valid,
    output out_sample,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_sample,
    output out_ready
  );

endinterface : signal_sample_capture_if

// File: rtl/signal_sample_capture_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO used as the capture buffer. The caller guarantees that
//   push is never asserted while full without a simultaneous pop, and that pop
//   is never asserted while empty; occupancy is tracked as a level count, not
//   by comparing pointers.
//   Parameters:
//     WIDTH - data width
//     DEPTH - number of entries, power of 2, >= 2
//   Ports:
//     clk_operation - clock, all logic on the rising edge
//     rst           - synchronous reset, active-high; clears pointers and level
//     push          - write din at the tail
//     pop           - remove the head entry
//     din           - write data
//     dout          - head entry (mem[rd_ptr])
//     level         - number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk_operation,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;

  // Pointers are exactly PTR_W bits, so they wrap modulo DEPTH by themselves.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk_operation) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage has no reset; stale entries are unreachable once pointers and level are cleared.
  always_ff @(posedge clk_operation) begin
    if (!rst && push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule : sync_fifo

// File: rtl/signal_sample_capture.sv
// -----------------------------------------------------------------------------
// signal_sample_capture
//   Receive side of the random signal generator. Captures the test signal on
//   every clock where the shared sampling-cycle counter equals CAPTURE_PHASE,
//   buffers the samples in a FIFO and drains them over a valid/ready handshake.
//   Captures that find the FIFO full (and no pop in the same clock) are
//   dropped, flagged by a sticky overflow bit and counted in a saturating
//   16-bit drop counter.
//   Parameters:
//     SAMPLE_W      - sample width
//     CNT_W         - sampling-cycle counter width
//     CAPTURE_PHASE - counter value that triggers a capture; nonzero because the
//                     generator changes signal on the counter==0 edge
//     DEPTH         - FIFO depth, power of 2, >= 2
//   Ports:
//     clk_operation          - operation clock
//     rst                    - synchronous reset, active-high
//     sampling_cycle_counter - shared sampling-cycle counter
//     signal                 - generator output, held for one sampling cycle
//     out_if                 - valid/ready drain (master side)
//     fill_level             - samples currently stored, 0..DEPTH
//     overflow               - sticky, a capture was dropped since reset
//     drop_count             - dropped captures, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module signal_sample_capture #(
  parameter int SAMPLE_W      = echo_pkg::SAMPLE_W,
  parameter int CNT_W         = echo_pkg::CNT_W,
  parameter int CAPTURE_PHASE = 1,
  parameter int DEPTH         = 16
) (
  input  logic                        clk_operation,
  input  logic                        rst,
  input  logic [CNT_W-1:0]            sampling_cycle_counter,
  input  logic [SAMPLE_W-1:0]         signal,
  signal_sample_capture_if.master     out_if,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [LVL_W-1:0] level;
  logic             cap;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic             drop;

  logic             overflow_q,   overflow_d;
  logic [15:0]      drop_count_q, drop_count_d;

  // A counter lingering at CAPTURE_PHASE captures once per clock it lingers.
  assign cap   = (sampling_cycle_counter == CNT_W'(CAPTURE_PHASE));
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  assign pop  = !empty && out_if.out_ready;
  // A pop in the same clock frees the slot a full FIFO needs for the capture.
  assign push = cap && (!full || pop);
  assign drop = cap && full && !pop;

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_operation (clk_operation),
    .rst           (rst),
    .push          (push),
    .pop           (pop),
    .din           (signal),
    .dout          (out_if.out_sample),
    .level         (level)
  );

  always_comb begin
    overflow_d   = overflow_q || drop;
    drop_count_d = drop ? echo_pkg::sat_inc16(drop_count_q) : drop_count_q;
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_if.out_valid = !empty;
  assign fill_level       = level;
  assign overflow         = overflow_q;
  assign drop_count       = drop_count_q;

endmodule : signal_sample_capture
